// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes, store-size codes.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    // Illegal funct3 encodings collapse to a word access.
    function automatic logic [1:0] f3_to_storetype(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return ST_BYTE;
            F3_LH, F3_LHU: return ST_HALF;
            default:       return ST_WORD;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load lane extraction: selects byte/half from an aligned word and sign/zero extends.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one held memory request per MEM-stage access, load extension, pipeline stall.
// Optional `MISALIGN_TRAP_EN rejects misaligned/illegal accesses with lsu_err instead of issuing them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N_Bits = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [N_Bits-1:0] lsu_addr,
    input  logic [N_Bits-1:0] lsu_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [N_Bits-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_storetype,
    output logic [N_Bits-1:0] mem_addr,
    output logic [N_Bits-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [N_Bits-1:0] mem_rdata
);

    lsu_state_e        state, state_next;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [1:0]        storetype_r;
    logic [N_Bits-1:0] addr_r, wdata_r, rdata_r;
    logic [31:0]       ext_word;
    logic              trap;

`ifdef MISALIGN_TRAP_EN
    logic err_r;
    logic [1:0] size_in;

    always_comb begin
        size_in = f3_to_storetype(lsu_funct3);
        trap = !f3_legal(lsu_funct3) ||
               ((size_in == ST_HALF) && lsu_addr[0]) ||
               ((size_in == ST_WORD) && (lsu_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_r <= 1'b0;
        else if (state == IDLE && lsu_valid)
            err_r <= trap;
    end

    assign lsu_err = (state == DONE) && err_r;
`else
    assign trap    = 1'b0;
    assign lsu_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lsu_valid) state_next = trap ? DONE : REQ;
            REQ:     if (mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .word   (mem_rdata[31:0]),
        .off    (addr_r[1:0]),
        .funct3 (funct3_r),
        .result (ext_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r        <= 1'b0;
            funct3_r    <= '0;
            storetype_r <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
        end else begin
            if (state == IDLE && lsu_valid) begin
                we_r        <= lsu_we;
                funct3_r    <= lsu_funct3;
                storetype_r <= f3_to_storetype(lsu_funct3);
                addr_r      <= lsu_addr;
                wdata_r     <= lsu_wdata;
            end
            if (state == REQ && mem_ready && !we_r)
                rdata_r <= N_Bits'(ext_word);
        end
    end

    assign mem_req       = (state == REQ);
    assign mem_we        = (state == REQ) && we_r;
    assign mem_storetype = storetype_r;
    assign mem_addr      = addr_r;
    assign mem_wdata     = wdata_r;
    assign lsu_done      = (state == DONE);
    assign lsu_rdata     = rdata_r;
    assign lsu_stall     = lsu_valid && !lsu_done;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses against a behavioural model.
// Define MISALIGN_TRAP_EN for both bench and RTL to exercise the trap build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid, lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_storetype;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_rdata = 32'd0;

    load_store_unit #(.N_Bits(32)) dut (
        .clk(clk), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_storetype(mem_storetype),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes: 1, 2 or 4; unknown encodings behave as words.
    function automatic int m_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_storetype(input logic [2:0] f3);
        return (m_bytes(f3) == 1) ? 32'd0 : (m_bytes(f3) == 2) ? 32'd1 : 32'd2;
    endfunction

    function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        bit legal;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || (addr % m_bytes(f3) != 0);
`else
        return (f3 == 3'd7) && (addr != addr);
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] v;
        int unsigned boff;
        boff = addr % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * boff)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * (boff / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // Starts at a negedge with the DUT idle; ends at the next idle negedge.
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word,
                          input int unsigned waits, input bit hold);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        mem_ready  = 1'b0;
        #1;
        chk("idle_stall", lsu_stall, 1);
        chk("idle_req", mem_req, 0);
        @(negedge clk);
        if (m_trap(f3, addr)) begin
            chk("trap_done", lsu_done, 1);
            chk("trap_err", lsu_err, 1);
            chk("trap_req", mem_req, 0);
            chk("trap_rdata", lsu_rdata, exp_rdata);
            chk("trap_stall", lsu_stall, 0);
        end else begin
            for (int i = 0; i <= int'(waits); i++) begin
                chk("req", mem_req, 1);
                chk("req_we", mem_we, we);
                chk("req_storetype", mem_storetype, m_storetype(f3));
                chk("req_addr", mem_addr, addr);
                chk("req_wdata", mem_wdata, wdata);
                chk("req_done", lsu_done, 0);
                chk("req_stall", lsu_stall, 1);
                if (i == int'(waits)) begin
                    mem_ready = 1'b1;
                    mem_rdata = word;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
            if (!we) exp_rdata = m_load(f3, addr, word);
            chk("done", lsu_done, 1);
            chk("done_err", lsu_err, 0);
            chk("done_req", mem_req, 0);
            chk("done_rdata", lsu_rdata, exp_rdata);
            chk("done_stall", lsu_stall, 0);
        end
        // A stray ready in DONE must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!hold) lsu_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("idle_done", lsu_done, 0);
        chk("idle_req_after", mem_req, 0);
        chk("idle_stall_after", lsu_stall, hold);
        chk("idle_rdata", lsu_rdata, exp_rdata);
    endtask

    initial begin
        reset      = 1'b1;
        lsu_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'd0;
        lsu_addr   = 32'd0;
        lsu_wdata  = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_err", lsu_err, 0);
        chk("rst_storetype", mem_storetype, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", lsu_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // LW, ready one cycle after the request appears
        access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        chk("t1_lw", lsu_rdata, 32'hDEADBEEF);

        // lane extraction on 0x80FF1234
        access(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF1234, 0, 1'b0);
        chk("t2_lb", lsu_rdata, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF1234, 1, 1'b0);
        chk("t2_lbu", lsu_rdata, 32'h00000080);
        access(1'b0, 3'b101, 32'h12, 32'h0, 32'h80FF1234, 0, 1'b0);
        chk("t2_lhu", lsu_rdata, 32'h000080FF);
        access(1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF1234, 0, 1'b0);
        chk("t2_lh", lsu_rdata, 32'hFFFF80FF);

        // SB held across three wait cycles; rdata keeps the last load
        access(1'b1, 3'b000, 32'h21, 32'h000000AB, 32'h55555555, 3, 1'b0);
        chk("t3_sb_rdata", lsu_rdata, 32'hFFFF80FF);

        // async reset in the middle of a request
        lsu_valid  = 1'b1;
        lsu_we     = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h40;
        lsu_wdata  = 32'h12345678;
        @(negedge clk);
        chk("t4_req_before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_req_async", mem_req, 0);
        chk("t4_we_async", mem_we, 0);
        chk("t4_done_async", lsu_done, 0);
        chk("t4_addr_async", mem_addr, 0);
        exp_rdata = 32'd0;
        chk("t4_rdata_async", lsu_rdata, 0);
        lsu_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        access(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, 2, 1'b0);

        // misaligned LW: trapped with the macro, issued as-is without
        access(1'b0, 3'b010, 32'h6, 32'h0, 32'h01020304, 0, 1'b0);
        // illegal funct3 behaves as a word access (or traps)
        access(1'b0, 3'b111, 32'h8, 32'h0, 32'hA5A5A5A5, 1, 1'b0);

        // back-to-back: store then load with lsu_valid held in between
        access(1'b1, 3'b001, 32'h30, 32'h0000BEEF, 32'h0, 1, 1'b1);
        access(1'b0, 3'b100, 32'h31, 32'h0, 32'h11223344, 0, 1'b0);
        chk("t6_lbu", lsu_rdata, 32'h00000033);

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        lsu_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
